// File: rtl/rect_probe_pkg.sv
// Shared screen geometry, colour and FSM definitions for the rectangle
// reader/writer pair on the 160x120 shadow framebuffer.
package rect_probe_pkg;

    localparam int SCR_X_MAX = 159;
    localparam int SCR_Y_MAX = 119;
    localparam int COLOR_W   = 3;

    localparam logic [COLOR_W-1:0] BLACK = '0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SCAN  = ST_SCAN,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
    } coord_t;

endpackage

// File: rtl/rect_scan_counter.sv
// Raster cx/cy walker over a width x height rectangle with screen clipping.
// Shared between the rectangle reader and writer.
module rect_scan_counter
    import rect_probe_pkg::*;
#(
    parameter int X_MAX = SCR_X_MAX,
    parameter int Y_MAX = SCR_Y_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [4:0] w,
    input  logic [4:0] h,
    output logic [7:0] px,
    output logic [6:0] py,
    output logic       in_bounds,
    output logic       last
);

    logic [4:0] cx, cy;
    logic [8:0] px_full;
    logic [7:0] py_full;
    logic       row_end;

    // One extra bit so a rectangle hanging off the right/bottom edge clips
    // instead of wrapping back onto column/row 0.
    assign px_full   = {1'b0, x0} + {4'b0, cx};
    assign py_full   = {1'b0, y0} + {3'b0, cy};
    assign in_bounds = (px_full <= 9'(X_MAX)) && (py_full <= 8'(Y_MAX));
    assign px        = px_full[7:0];
    assign py        = py_full[6:0];

    assign row_end = (cx == w - 5'd1);
    assign last    = row_end && (cy == h - 5'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cx <= '0;
            cy <= '0;
        end else if (clear) begin
            cx <= '0;
            cy <= '0;
        end else if (advance) begin
            if (row_end) begin
                cx <= '0;
                cy <= cy + 5'd1;
            end else begin
                cx <= cx + 5'd1;
            end
        end
    end

endmodule

// File: rtl/rect_probe.sv
// Reads a rectangle back from the shadow framebuffer and reports whether any
// pixel differs from a background colour, the first such pixel and a count.
module rect_probe
    import rect_probe_pkg::*;
#(
    parameter int RD_LAT      = 1,      // 1..3
    parameter bit STOP_ON_HIT = 1'b0,
    parameter int X_MAX       = SCR_X_MAX,
    parameter int Y_MAX       = SCR_Y_MAX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         x_in,
    input  logic [6:0]         y_in,
    input  logic [4:0]         width,
    input  logic [4:0]         height,
    input  logic [COLOR_W-1:0] bg_color,
    output logic               rd_en,
    output logic [7:0]         rd_x,
    output logic [6:0]         rd_y,
    input  logic [COLOR_W-1:0] rd_data,
    output logic               busy,
    output logic               done,
    output logic               hit,
    output logic [7:0]         hit_x,
    output logic [6:0]         hit_y,
    output logic [9:0]         hit_count
);

    state_t             state;
    logic [7:0]         x_q;
    logic [6:0]         y_q;
    logic [4:0]         w_q, h_q;
    logic [COLOR_W-1:0] bg_q;

    logic       launch, empty, scanning;
    logic [7:0] px;
    logic [6:0] py;
    logic       in_bounds, last;

    logic [RD_LAT:1] vld_pipe;
    coord_t [RD_LAT:1] crd_pipe;
    logic       inflight, tail_hit;

    assign launch   = start && (state == IDLE || state == DONE);
    assign empty    = (w_q == 5'd0) || (h_q == 5'd0);
    assign scanning = (state == SCAN);

    rect_scan_counter #(
        .X_MAX(X_MAX),
        .Y_MAX(Y_MAX)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (launch),
        .advance  (scanning),
        .x0       (x_q),
        .y0       (y_q),
        .w        (w_q),
        .h        (h_q),
        .px       (px),
        .py       (py),
        .in_bounds(in_bounds),
        .last     (last)
    );

    // Clipped pixels still burn a scan cycle but never reach the pipe.
    assign rd_en = scanning && !empty && in_bounds;
    assign rd_x  = rd_en ? px : '0;
    assign rd_y  = rd_en ? py : '0;
    assign busy  = (state == SCAN) || (state == DRAIN);
    assign done  = (state == DONE);

    assign tail_hit = vld_pipe[RD_LAT] && (rd_data != bg_q);

    // The tail entry is consumed on the coming edge, so only the stages
    // ahead of it keep DRAIN waiting.
    always_comb begin
        inflight = 1'b0;
        for (int k = 1; k < RD_LAT; k++)
            inflight = inflight | vld_pipe[k];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            bg_q      <= BLACK;
            vld_pipe  <= '0;
            crd_pipe  <= '0;
            hit       <= 1'b0;
            hit_x     <= '0;
            hit_y     <= '0;
            hit_count <= '0;
        end else begin
            vld_pipe[1] <= rd_en;
            crd_pipe[1] <= '{x: px, y: py};
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                crd_pipe[k] <= crd_pipe[k-1];
            end

            if (tail_hit) begin
                hit_count <= hit_count + 10'd1;
                if (!hit) begin
                    hit   <= 1'b1;
                    hit_x <= crd_pipe[RD_LAT].x;
                    hit_y <= crd_pipe[RD_LAT].y;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        x_q       <= x_in;
                        y_q       <= y_in;
                        w_q       <= width;
                        h_q       <= height;
                        bg_q      <= bg_color;
                        hit       <= 1'b0;
                        hit_x     <= '0;
                        hit_y     <= '0;
                        hit_count <= '0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (empty)
                        state <= DONE;
                    else if ((STOP_ON_HIT && tail_hit) || last)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!inflight)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_probe.sv
// Bench for rect_probe: one instance with RD_LAT=1 and one with RD_LAT=2 and
// STOP_ON_HIT=1, each fed by a framebuffer model with the matching latency.
module tb_rect_probe;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, start_b = 1'b0;
    logic [7:0] x_in = '0;
    logic [6:0] y_in = '0;
    logic [4:0] width = '0, height = '0;
    logic [2:0] bg_color = '0;

    logic       a_rd_en, a_busy, a_done, a_hit;
    logic [7:0] a_rd_x, a_hit_x;
    logic [6:0] a_rd_y, a_hit_y;
    logic [9:0] a_hit_count;
    logic [2:0] a_rd_data;
    logic       b_rd_en, b_busy, b_done, b_hit;
    logic [7:0] b_rd_x, b_hit_x;
    logic [6:0] b_rd_y, b_hit_y;
    logic [9:0] b_hit_count;
    logic [2:0] b_rd_data;

    rect_probe #(.RD_LAT(1), .STOP_ON_HIT(1'b0)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .x_in(x_in), .y_in(y_in),
        .width(width), .height(height), .bg_color(bg_color),
        .rd_en(a_rd_en), .rd_x(a_rd_x), .rd_y(a_rd_y), .rd_data(a_rd_data),
        .busy(a_busy), .done(a_done), .hit(a_hit), .hit_x(a_hit_x),
        .hit_y(a_hit_y), .hit_count(a_hit_count)
    );

    rect_probe #(.RD_LAT(2), .STOP_ON_HIT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .x_in(x_in), .y_in(y_in),
        .width(width), .height(height), .bg_color(bg_color),
        .rd_en(b_rd_en), .rd_x(b_rd_x), .rd_y(b_rd_y), .rd_data(b_rd_data),
        .busy(b_busy), .done(b_done), .hit(b_hit), .hit_x(b_hit_x),
        .hit_y(b_hit_y), .hit_count(b_hit_count)
    );

    // Framebuffer model; idle cycles put garbage on rd_data.
    logic [2:0] fb [0:19199];
    logic [2:0] ra_q, rb_q1, rb_q2;

    function automatic logic [2:0] pix(input int x, input int y);
        if (x >= 0 && x <= 159 && y >= 0 && y <= 119) return fb[y*160 + x];
        return 3'd7;
    endfunction

    always @(posedge clk) begin
        ra_q  <= a_rd_en ? pix(int'(a_rd_x), int'(a_rd_y)) : 3'($urandom);
        rb_q1 <= b_rd_en ? pix(int'(b_rd_x), int'(b_rd_y)) : 3'($urandom);
        rb_q2 <= rb_q1;
    end
    assign a_rd_data = ra_q;
    assign b_rd_data = rb_q2;

    int qa[$], qb[$];
    always @(negedge clk) begin
        if (a_rd_en) qa.push_back(int'(a_rd_x) * 128 + int'(a_rd_y));
        if (b_rd_en) qb.push_back(int'(b_rd_x) * 128 + int'(b_rd_y));
    end

    bit sel_g = 1'b0;
    logic       m_busy, m_done, m_hit;
    logic [7:0] m_hit_x;
    logic [6:0] m_hit_y;
    logic [9:0] m_hit_count;
    assign m_busy      = sel_g ? b_busy      : a_busy;
    assign m_done      = sel_g ? b_done      : a_done;
    assign m_hit       = sel_g ? b_hit       : a_hit;
    assign m_hit_x     = sel_g ? b_hit_x     : a_hit_x;
    assign m_hit_y     = sel_g ? b_hit_y     : a_hit_y;
    assign m_hit_count = sel_g ? b_hit_count : a_hit_count;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int bg, input int density);
        for (int i = 0; i < 19200; i++)
            fb[i] = (density > 0 && $urandom_range(0, density - 1) == 0) ? 3'($urandom) : 3'(bg);
    endtask

    // Reference: list the visible pixels in raster order, truncate at the
    // stop point for the STOP_ON_HIT instance, then score that list.
    task automatic run(input bit sel, input int x, input int y, input int w,
                       input int h, input int bg, input string tag);
        int exp_rd[$];
        int got[$];
        int n, hits, fx, fy, kf, lat, exp_lat;
        bit poke;
        for (int dy = 0; dy < h; dy++)
            for (int dx = 0; dx < w; dx++)
                if (x + dx <= 159 && y + dy <= 119) exp_rd.push_back((x + dx) * 128 + y + dy);
        kf = -1;
        foreach (exp_rd[i])
            if (kf < 0 && pix(exp_rd[i] / 128, exp_rd[i] % 128) != 3'(bg)) kf = i;
        n = exp_rd.size();
        if (sel && kf >= 0 && kf + 3 < n) n = kf + 3;
        hits = 0; fx = 0; fy = 0;
        for (int i = 0; i < n; i++)
            if (pix(exp_rd[i] / 128, exp_rd[i] % 128) != 3'(bg)) begin
                if (hits == 0) begin fx = exp_rd[i] / 128; fy = exp_rd[i] % 128; end
                hits++;
            end
        if (w == 0 || h == 0) exp_lat = 1;
        else if (sel)         exp_lat = n + 2;
        else                  exp_lat = w * h + 1;
        poke = (exp_lat >= 4);

        @(negedge clk);
        sel_g = sel;
        x_in = 8'(x); y_in = 7'(y); width = 5'(w); height = 5'(h); bg_color = 3'(bg);
        if (sel) begin qb = {}; start_b = 1'b1; end
        else     begin qa = {}; start_a = 1'b1; end
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        // Scrambled inputs must not matter once the request is latched.
        x_in = 8'($urandom); y_in = 7'($urandom); width = 5'($urandom);
        height = 5'($urandom); bg_color = 3'($urandom);
        chk({tag, ".done_fall"}, m_done, 0);
        chk({tag, ".busy"}, m_busy, 1);
        lat = 0;
        while (!m_done && lat < 3000) begin
            if (poke && lat == 1) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0; start_b = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start_a = 1'b0; start_b = 1'b0;
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".busy_end"}, m_busy, 0);
        chk({tag, ".hit"}, m_hit, hits > 0);
        chk({tag, ".hit_x"}, m_hit_x, fx);
        chk({tag, ".hit_y"}, m_hit_y, fy);
        chk({tag, ".hit_count"}, m_hit_count, hits);
        got = sel ? qb : qa;
        chk({tag, ".reads"}, got.size(), n);
        for (int i = 0; i < got.size() && i < n; i++)
            if (got[i] != exp_rd[i]) chk({tag, ".read_xy"}, got[i], exp_rd[i]);
    endtask

    initial begin
        int x, y, w, h, bg;
        fill(0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst.a_rd_en", a_rd_en, 0);
        chk("rst.a_busy", a_busy, 0);
        chk("rst.a_done", a_done, 0);
        chk("rst.a_hit_count", a_hit_count, 0);
        chk("rst.b_rd_en", b_rd_en, 0);
        chk("rst.b_done", b_done, 0);
        chk("rst.b_hit", b_hit, 0);
        @(negedge clk);
        reset = 1'b1;

        run(0, 10, 20, 4, 3, 0, "black");
        fb[21*160 + 12] = 3'b100;
        fb[22*160 + 13] = 3'b010;
        run(0, 10, 20, 4, 3, 0, "two_hits");
        fb[118*160 + 159] = 3'd5;
        run(0, 158, 118, 4, 4, 0, "corner_clip");
        run(0, 5, 5, 0, 5, 0, "w_zero");
        run(1, 5, 5, 3, 0, 0, "h_zero_b");

        fill(0, 0);
        fb[40*160 + 30] = 3'd1;
        fb[40*160 + 31] = 3'd6;
        run(1, 30, 40, 8, 8, 0, "stop_first");
        run(1, 60, 60, 8, 8, 0, "stop_none");
        fb[62*160 + 65] = 3'd3;
        run(1, 60, 60, 8, 8, 0, "stop_mid");

        // Reset in the middle of a scan that has already collected hits.
        fill(0, 2);
        @(negedge clk);
        sel_g = 1'b0;
        x_in = 8'd0; y_in = 7'd0; width = 5'd20; height = 5'd20; bg_color = 3'd0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort.busy_before", a_busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort.busy", a_busy, 0);
        chk("abort.rd_en", a_rd_en, 0);
        chk("abort.rd_x", a_rd_x, 0);
        chk("abort.hit", a_hit, 0);
        chk("abort.hit_count", a_hit_count, 0);
        chk("abort.hit_x", a_hit_x, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort.idle_done", a_done, 0);
        chk("abort.idle_busy", a_busy, 0);

        run(0, 140, 100, 31, 31, 3, "big_clip");
        for (int t = 0; t < 15; t++) begin
            bg = $urandom_range(0, 7);
            fill(bg, $urandom_range(1, 12));
            x = $urandom_range(0, 165); y = $urandom_range(0, 125);
            w = $urandom_range(0, 12);  h = $urandom_range(0, 12);
            run(0, x, y, w, h, bg, "rand_a");
        end
        for (int t = 0; t < 12; t++) begin
            bg = $urandom_range(0, 7);
            fill(bg, $urandom_range(4, 40));
            w = $urandom_range(0, 10);  h = $urandom_range(0, 10);
            x = $urandom_range(0, 150); y = $urandom_range(0, 110);
            run(1, x, y, w, h, bg, "rand_b");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
